// File: rtl/barret_pipe_reducer_if.sv
// barret_pipe_reducer_if: valid/ready stream bundle for the Barrett reducer
interface barret_pipe_reducer_if #(
   parameter int K     = 12,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [2*K-1:0]   in_a;
   logic [K-1:0]     in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [K-1:0]     dout_r;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;
   modport master (
      output in_valid, in_mode, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, dout_r, out_tag, out_err
   );
   modport slave (
      input  in_valid, in_mode, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, dout_r, out_tag, out_err
   );
endinterface

// File: rtl/barret_pipe_reducer.sv
// barret_pipe_reducer: 4-stage pipelined Barrett reduction of a value or K x K product mod Q
module barret_pipe_reducer #(
   parameter int Q     = 2423,
   parameter int K     = 12,
   parameter int MU    = 6924,
   parameter int TAG_W = 4
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  flush,
   barret_pipe_reducer_if.slave bus
);
   localparam int             W   = 2 * K;
   localparam logic [K-1:0]   QK  = K'(Q);
   localparam logic [K+1:0]   Q1  = (K + 2)'(Q);
   localparam logic [K+1:0]   Q2  = (K + 2)'(2 * Q);
   localparam logic [W+1:0]   MUW = (W + 2)'(MU);

   if (Q < 3 || Q % 2 == 0 || K != $clog2(Q) || MU != int'((64'd1 << W) / Q)) begin : g_param_chk
      $error("barret_pipe_reducer: Q/K/MU are inconsistent");
   end

   logic             v1_q, v2_q, v3_q, v4_q, v1_d, v2_d, v3_d, v4_d;
   logic             en1, en2, en3, en4;
   logic [W-1:0]     x1_q, x1_d;
   logic [K+1:0]     x2_q;
   logic [W+1:0]     p2_q, p2_d;
   logic [K+1:0]     qe, r3_q, r3_d;
   logic [K-1:0]     d4_q, d4_d;
   logic             e1_q, e1_d, e2_q, e3_q, e4_q;
   logic [TAG_W-1:0] t1_q, t2_q, t3_q, t4_q;

   // Remainder arithmetic only needs the low K+2 bits since R < 3Q < 2^(K+2).
   always_comb begin
      en4          = ~v4_q | bus.out_ready;
      en3          = ~v3_q | en4;
      en2          = ~v2_q | en3;
      en1          = ~v1_q | en2;
      bus.in_ready = en1 & ~flush;
      v1_d         = flush ? 1'b0 : en1 ? bus.in_valid : v1_q;
      v2_d         = flush ? 1'b0 : en2 ? v1_q : v2_q;
      v3_d         = flush ? 1'b0 : en3 ? v2_q : v3_q;
      v4_d         = flush ? 1'b0 : en4 ? v3_q : v4_q;
      x1_d         = bus.in_mode ? {{K{1'b0}}, bus.in_a[K-1:0]} * {{K{1'b0}}, bus.in_b} : bus.in_a;
      e1_d         = bus.in_mode & (bus.in_a[K-1:0] >= QK | bus.in_b >= QK);
      p2_d         = (W + 2)'(x1_q >> (K - 1)) * MUW;
      qe           = (K + 2)'(p2_q >> (K + 1));
      r3_d         = x2_q - qe * Q1;
      d4_d         = K'(r3_q >= Q2 ? r3_q - Q2 : r3_q >= Q1 ? r3_q - Q1 : r3_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {v1_q, v2_q, v3_q, v4_q} <= '0;
         {e1_q, e2_q, e3_q, e4_q} <= '0;
         x1_q <= '0;
         x2_q <= '0;
         p2_q <= '0;
         r3_q <= '0;
         d4_q <= '0;
         t1_q <= '0;
         t2_q <= '0;
         t3_q <= '0;
         t4_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         v4_q <= v4_d;
         if (en1) begin
            x1_q <= x1_d;
            e1_q <= e1_d;
            t1_q <= bus.in_tag;
         end
         if (en2) begin
            x2_q <= x1_q[K+1:0];
            p2_q <= p2_d;
            e2_q <= e1_q;
            t2_q <= t1_q;
         end
         if (en3) begin
            r3_q <= r3_d;
            e3_q <= e2_q;
            t3_q <= t2_q;
         end
         if (en4) begin
            d4_q <= d4_d;
            e4_q <= e3_q;
            t4_q <= t3_q;
         end
      end
   end

   assign bus.out_valid = v4_q;
   assign bus.dout_r    = d4_q;
   assign bus.out_tag   = t4_q;
   assign bus.out_err   = e4_q;
endmodule

// File: tb/tb_barret_pipe_reducer.sv
// tb_barret_pipe_reducer: directed table plus stall/flush/reset sequences and random golden-model runs
module tb_barret_pipe_reducer;
   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   barret_pipe_reducer_if #(.K(12), .TAG_W(4)) bi ();
   barret_pipe_reducer_if #(.K(12), .TAG_W(4)) bi3 ();

   barret_pipe_reducer #(.Q(2423), .K(12), .MU(6924), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bi.slave));
   barret_pipe_reducer #(.Q(3329), .K(12), .MU(5039), .TAG_W(4)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .bus(bi3.slave));

   assign bi3.in_valid  = bi.in_valid;
   assign bi3.in_mode   = bi.in_mode;
   assign bi3.in_a      = bi.in_a;
   assign bi3.in_b      = bi.in_b;
   assign bi3.in_tag    = bi.in_tag;
   assign bi3.out_ready = bi.out_ready;

   typedef struct {
      logic [11:0] d;
      logic [3:0]  tag;
      logic        err;
      int          cyc;
   } rec_t;

   typedef struct {
      logic        mode;
      logic [23:0] a;
      logic [11:0] b;
      logic [11:0] d;
      logic        err;
   } vec_t;

   typedef struct {
      logic [11:0] d1;
      logic [11:0] d3;
      logic        e1;
      logic        e3;
      logic [3:0]  t;
   } exp_t;

   rec_t oq[$];
   rec_t oq3[$];
   int   iq[$];
   exp_t ex[$];
   localparam int NV = 10;
   vec_t tbl[NV];
   bit   rnd_on;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic m, input logic [23:0] a, input logic [11:0] b, input logic [3:0] t);
      bit acc = 1'b0;
      bi.in_valid = 1'b1;
      bi.in_mode  = m;
      bi.in_a     = a;
      bi.in_b     = b;
      bi.in_tag   = t;
      for (int n = 0; n < 64 && !acc; n++) begin
         @(negedge clk);
         acc = bi.in_ready;
         @(posedge clk);
         #1;
      end
      bi.in_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: tag %0d never accepted", t);
      end
   endtask

   always @(negedge clk) begin
      if (bi.in_valid && bi.in_ready) iq.push_back(cyc);
      if (bi.out_valid && bi.out_ready) begin
         oq.push_back('{d: bi.dout_r, tag: bi.out_tag, err: bi.out_err, cyc: cyc});
         chk("range_q2423", 64'(bi.dout_r < 12'd2423), 64'd1);
      end
      if (bi3.out_valid && bi3.out_ready) begin
         oq3.push_back('{d: bi3.dout_r, tag: bi3.out_tag, err: bi3.out_err, cyc: cyc});
         chk("range_q3329", 64'(bi3.dout_r < 12'd3329), 64'd1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{mode: 1'b0, a: 24'd0,        b: 12'd4095, d: 12'd0,    err: 1'b0};
      tbl[1] = '{mode: 1'b0, a: 24'd2423,     b: 12'd4095, d: 12'd0,    err: 1'b0};
      tbl[2] = '{mode: 1'b0, a: 24'd16777215, b: 12'd0,    d: 12'd363,  err: 1'b0};
      tbl[3] = '{mode: 1'b1, a: 24'd2422,     b: 12'd2422, d: 12'd1,    err: 1'b0};
      tbl[4] = '{mode: 1'b1, a: 24'd1234,     b: 12'd5,    d: 12'd1324, err: 1'b0};
      tbl[5] = '{mode: 1'b1, a: 24'd0,        b: 12'd2422, d: 12'd0,    err: 1'b0};
      tbl[6] = '{mode: 1'b1, a: 24'd2423,     b: 12'd1,    d: 12'd0,    err: 1'b1};
      tbl[7] = '{mode: 1'b1, a: 24'd4095,     b: 12'd4095, d: 12'd1865, err: 1'b1};
      tbl[8] = '{mode: 1'b1, a: 24'hFFF005,   b: 12'd3,    d: 12'd15,   err: 1'b0};
      tbl[9] = '{mode: 1'b0, a: 24'd4845,     b: 12'd0,    d: 12'd2422, err: 1'b0};

      rst = 1'b1;
      flush = 1'b0;
      bi.in_valid = 1'b0;
      bi.in_mode = 1'b0;
      bi.in_a = '0;
      bi.in_b = '0;
      bi.in_tag = '0;
      bi.out_ready = 1'b1;
      wait_cycles(2);
      chk("rst_out_valid", bi.out_valid, 0);
      chk("rst_dout", bi.dout_r, 0);
      chk("rst_tag", bi.out_tag, 0);
      chk("rst_err", bi.out_err, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", bi.in_ready, 1);
      wait_cycles(1);

      // Directed table, back to back at full rate
      iq.delete();
      oq.delete();
      for (int i = 0; i < NV; i++) send(tbl[i].mode, tbl[i].a, tbl[i].b, 4'(i));
      wait_cycles(8);
      chk("tbl_count", oq.size(), NV);
      chk("tbl_in_count", iq.size(), NV);
      for (int i = 0; i < NV && i < oq.size() && i < iq.size(); i++) begin
         chk($sformatf("tbl%0d_dout", i), oq[i].d, tbl[i].d);
         chk($sformatf("tbl%0d_err", i), oq[i].err, tbl[i].err);
         chk($sformatf("tbl%0d_tag", i), oq[i].tag, i);
         chk($sformatf("tbl%0d_latency", i), oq[i].cyc - iq[i], 4);
      end

      // Backpressure: fill to 4, hold, then drain while still accepting
      iq.delete();
      oq.delete();
      bi.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(1'b0, 24'(i * 1000 + 7), 12'd0, 4'(i));
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            chk("full_in_ready", bi.in_ready, 0);
            chk("full_out_valid", bi.out_valid, 1);
            chk("full_accepted", iq.size(), 4);
            bi.out_ready = 1'b1;
         end
      join
      wait_cycles(12);
      chk("stall_out_count", oq.size(), 8);
      chk("stall_in_count", iq.size(), 8);
      for (int i = 0; i < 8 && i < oq.size(); i++) begin
         chk($sformatf("stall%0d_tag", i), oq[i].tag, i);
         chk($sformatf("stall%0d_dout", i), oq[i].d, (i * 1000 + 7) % 2423);
         if (i > 0) chk($sformatf("stall%0d_gap", i), oq[i].cyc - oq[i-1].cyc, 1);
      end
      if (iq.size() > 4 && oq.size() > 0) chk("full_swap_cycle", oq[0].cyc, iq[4]);

      // Flush drops in-flight items and refuses the offered one
      iq.delete();
      oq.delete();
      for (int i = 1; i <= 3; i++) send(1'b0, 24'd100, 12'd0, 4'(i));
      bi.in_valid = 1'b1;
      bi.in_mode = 1'b0;
      bi.in_a = 24'd77;
      bi.in_tag = 4'd5;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", bi.in_ready, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      bi.in_valid = 1'b0;
      chk("flush_out_valid", bi.out_valid, 0);
      send(1'b0, 24'd4846, 12'd0, 4'd9);
      wait_cycles(8);
      chk("flush_count", oq.size(), 1);
      if (oq.size() > 0) begin
         chk("flush_tag", oq[0].tag, 9);
         chk("flush_dout", oq[0].d, 0);
      end

      // Asynchronous reset with a full pipeline
      iq.delete();
      oq.delete();
      bi.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(1'b0, 24'd500, 12'd0, 4'(i));
      chk("pre_rst_valid", bi.out_valid, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", bi.out_valid, 0);
      chk("async_rst_valid3", bi3.out_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bi.out_ready = 1'b1;
      wait_cycles(6);
      chk("post_rst_empty", oq.size(), 0);

      // Random vectors against x mod Q for both moduli, random backpressure
      iq.delete();
      oq.delete();
      oq3.delete();
      rnd_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic        m;
               logic [23:0] a;
               logic [11:0] b;
               longint      x;
               m = 1'($urandom_range(1));
               a = 24'($urandom);
               b = 12'($urandom);
               if (i % 50 == 0) a = 24'hFFFFFF;
               if (i % 97 == 0) b = 12'hFFF;
               send(m, a, b, 4'(i));
               x = m ? longint'(a[11:0]) * longint'(b) : longint'(a);
               ex.push_back('{d1: 12'(x % 2423), d3: 12'(x % 3329),
                              e1: m && (a[11:0] >= 12'd2423 || b >= 12'd2423),
                              e3: m && (a[11:0] >= 12'd3329 || b >= 12'd3329), t: 4'(i)});
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1;
               bi.out_ready = ($urandom_range(3) != 0);
            end
         end
      join
      bi.out_ready = 1'b1;
      wait_cycles(12);
      chk("rnd_count", oq.size(), 1000);
      chk("rnd3_count", oq3.size(), 1000);
      for (int i = 0; i < ex.size() && i < oq.size(); i++)
         chk($sformatf("rnd%0d_q2423", i), {oq[i].d, oq[i].err, oq[i].tag}, {ex[i].d1, ex[i].e1, ex[i].t});
      for (int i = 0; i < ex.size() && i < oq3.size(); i++)
         chk($sformatf("rnd%0d_q3329", i), {oq3[i].d, oq3[i].err, oq3[i].tag}, {ex[i].d3, ex[i].e3, ex[i].t});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/barret_pipe_reducer.md
Name: barret_pipe_reducer

Overview:
Parametrised, fully pipelined Barrett modular reducer for an arbitrary odd modulus Q. Each accepted item is either a raw value A (reduce mode) or a product A*B (multiply mode), reduced to [0, Q). Valid/ready streaming with backpressure and a pass-through tag. Sits between NTT/butterfly datapaths and coefficient buffers, one result per clock at full rate.

Parameters:
Q, 2423, modulus; odd, >= 3.
K, 12, bit width of Q; equals ceil(log2(Q)). Coefficients are K bits.
MU, 6924, floor(2^(2K)/Q); precomputed by the instantiator; elaboration-time check of both K and MU.
TAG_W, 4, width of the sideband tag carried alongside each item.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous; drops all in-flight items.
in_valid  in  1  input item present.
in_ready  out  1  block accepts this cycle.
in_mode  in  1  0 = reduce in_a; 1 = reduce in_a[K-1:0]*in_b.
in_a  in  2K  operand / value to reduce.
in_b  in  K  multiplier; ignored when in_mode = 0.
in_tag  in  TAG_W  passed through unchanged.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts.
dout_r  out  K  result, 0 <= dout_r < Q.
out_tag  out  TAG_W  tag of this result.
out_err  out  1  multiply-mode operand was >= Q.

Behaviour:
- Reset (async, active-high): all stage valid bits = 0. out_valid = 0, dout_r = 0, out_tag = 0, out_err = 0. in_ready = 1 once rst is low. Data registers may also be cleared.
- Transfer on the input when in_valid & in_ready; transfer on the output when out_valid & out_ready.
- Four register stages (S1..S4), each with its own valid bit:
  - S1 registers X = in_a (mode 0) or X = in_a[K-1:0]*in_b, which is < 2^(2K). It also registers err = mode & (in_a[K-1:0] >= Q | in_b >= Q), plus the tag.
  - S2 registers X and P = (X >> (K-1)) * MU, with P width 2K+2.
  - S3 registers X and R = X - (P >> (K+1))*Q. R is computed modulo 2^(K+2) and is guaranteed < 3Q.
  - S4 registers the corrected result: R - 2Q if R >= 2Q; R - Q if R >= Q; else R. Both compares are evaluated in parallel. Outputs are driven directly from S4 registers.
- Latency: exactly 4 cycles from input transfer to out_valid when there are no stalls. Throughput is 1 item/cycle.
- Flow control (bubble-collapsing):
  - en4 = ~v4 | out_ready; en_i = ~v_i | en_{i+1}; in_ready = en1.
  - A stage loads when its enable is high. A stage holds value and data when its enable is low.
  - The combinational path from out_ready to in_ready is permitted.
- Boundary conditions:
  - Pipeline full with out_ready = 0: in_ready = 0. Up to 4 items are held with no loss or duplication.
  - Order is strictly FIFO.
  - Simultaneous input and output transfer while full: both occur and the occupancy stays at 4.
  - flush: all valid bits clear at the next edge and the input offered that cycle is not accepted (in_ready = 0 while flush = 1). Flush takes priority over everything except rst.
  - rst asserted mid-operation: all items are discarded immediately, without waiting for a clock edge.
  - Multiply mode with an out-of-range operand: the result is still (a*b) mod Q using the K-bit truncated a, and out_err = 1.
  - Mode 0 with in_a = 2^(2K)-1: must reduce correctly (worst case of the Barrett error bound).
  - dout_r is always < Q whenever out_valid = 1.

Test Plan:
1. Reset, then mode 0 with in_a = 0, 2423, 16777215, out_ready = 1 -> dout_r = 0, 0, 363 on cycles 4, 5, 6 after the first accept; out_err = 0.
2. Mode 1 with (a, b) = (2422, 2422), (1234, 5), (0, 2422) -> dout_r = 1, 1324, 0; out_err = 0.
3. Mode 1 with a = 2423, b = 1 -> dout_r = 0, out_err = 1.
4. Stream tags 0..7 back to back with out_ready low from cycle 2 to cycle 6 -> in_ready falls once 4 items are in flight. All 8 results emerge in tag order 0..7 with no gaps or duplicates once out_ready rises.
5. Load 3 items, assert flush for 1 cycle, then send tag 9 with in_a = 4846 -> only tag 9 emerges, with dout_r = 0.
6. Assert rst asynchronously while 4 items are in flight -> out_valid drops immediately; 1000 random mode-0/1 vectors after release match a golden model (x mod Q) for Q = 2423, and for Q = 3329, K = 12, MU = 5039.
